// File: rtl/ibex_obi_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus: word memory, byte-masked writes, fixed-latency in-order responses.
// Optional IBEX_RESP_ERR_EN: out-of-range accesses get an error response instead of aliasing.
module ibex_obi_responder #(
  parameter int unsigned MEM_WORDS       = 256,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      mem [MEM_WORDS];
  logic [CNT_W-1:0] outstanding;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             accept;
  logic             unused_offset;

  logic             pipe_valid [LATENCY];
  logic [31:0]      pipe_data  [LATENCY];
  logic             pipe_err   [LATENCY];

  assign offset = addr_i - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];

`ifdef IBEX_RESP_ERR_EN
  assign in_range      = (offset[31:IDX_W+2] == '0);
  assign unused_offset = ^offset[1:0];
`else
  assign in_range      = 1'b1;
  assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};
`endif

  // Grant uses the registered count, so a response landing while full does not free a slot until next cycle.
  assign gnt_o  = req_i && !stall_i && !reset && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign accept = req_i && gnt_o;

  always_ff @(posedge clock) begin
    if (accept && we_i && in_range) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= '0;
        pipe_err[i]   <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_data[0]  <= (accept && !we_i && in_range) ? mem[idx] : '0;
      pipe_err[0]   <= accept && !in_range;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid[LATENCY-1];
  assign rdata_o  = pipe_data[LATENCY-1];
  assign err_o    = pipe_err[LATENCY-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, rvalid_o})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
